// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: stage/butterfly sequencer for an in-place radix-2 FFT engine.
// Build macro FFT_SEQ_STALL_EN adds an i_stall input that freezes issue in RUN.
module fft_seq_ctrl #(
    parameter int R        = 5,
    parameter int PIPE_LAT = 3
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_start,
`ifdef FFT_SEQ_STALL_EN
    input  logic         i_stall,
`endif
    output logic         o_busy,
    output logic         o_done,
    output logic         o_rd_en,
    output logic [3:0]   o_c,
    output logic [R-2:0] o_b,
    output logic         o_s,
    output logic         o_wr_en,
    output logic [3:0]   o_wr_c,
    output logic [R-2:0] o_wr_b,
    output logic         o_wr_s
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam int              BW     = R - 1;
    localparam logic [3:0]      C_LAST = 4'(R - 1);
    localparam logic [3:0]      D_LAST = 4'(PIPE_LAT - 1);
    localparam logic [BW-1:0]   B_LAST = '1;

    state_e        state_q, state_d;
    logic [3:0]    c_q, c_d;
    logic [BW-1:0] b_q, b_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic          stall;
    logic          issue;

    logic [PIPE_LAT-1:0] pv_q;
    logic [PIPE_LAT-1:0] ps_q;
    logic [3:0]          pc_q [PIPE_LAT];
    logic [BW-1:0]       pb_q [PIPE_LAT];

`ifdef FFT_SEQ_STALL_EN
    assign stall = i_stall;
`else
    assign stall = 1'b0;
`endif

    // A butterfly is issued in every non-stalled RUN cycle.
    assign issue   = (state_q == RUN) && !stall;
    assign o_rd_en = issue;
    assign o_c     = issue ? c_q : 4'd0;
    assign o_b     = issue ? b_q : '0;
    assign o_s     = issue ? ^b_q : 1'b0;
    assign o_busy  = (state_q == RUN) || (state_q == DRAIN);
    assign o_done  = (state_q == DONE);

    assign o_wr_en = pv_q[PIPE_LAT-1];
    assign o_wr_c  = pc_q[PIPE_LAT-1];
    assign o_wr_b  = pb_q[PIPE_LAT-1];
    assign o_wr_s  = ps_q[PIPE_LAT-1];

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            c_q     <= '0;
            b_q     <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            b_q     <= b_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Next-state logic: issue all butterflies, then drain the pipeline.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        b_d     = b_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                    c_d     = '0;
                    b_d     = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (b_q == B_LAST) begin
                        b_d     = '0;
                        dcnt_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (dcnt_q == D_LAST) begin
                    dcnt_d = '0;
                    if (c_q == C_LAST) begin
                        c_d     = '0;
                        state_d = DONE;
                    end else begin
                        c_d     = c_q + 4'd1;
                        state_d = RUN;
                    end
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write-back shift register; advances every cycle, bubbles included.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pv_q <= '0;
            ps_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pc_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= issue;
            ps_q[0] <= o_s;
            pc_q[0] <= o_c;
            pb_q[0] <= o_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                ps_q[i] <= ps_q[i-1];
                pc_q[i] <= pc_q[i-1];
                pb_q[i] <= pb_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: randomized self-checking bench for fft_seq_ctrl.
// Expected traces come from the closed-form stage/butterfly schedule.
module tb_fft_seq_ctrl;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd;
        logic [3:0]  c;
        logic [15:0] b;
        logic        s;
        logic        wr;
        logic [3:0]  wc;
        logic [15:0] wb;
        logic        ws;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic start, st2, st4;
    logic busy, done, rd_en, s, wr_en, wr_s;
    logic [3:0] c, wr_c;
    logic [3:0] b, wr_b;
    logic busy2, done2, rd2, s2, wr2, ws2;
    logic [3:0] c2, wc2;
    logic [0:0] b2, wb2;
    logic busy4, done4, rd4, s4, wr4, ws4;
    logic [3:0] c4, wc4;
    logic [2:0] b4, wb4;
`ifdef FFT_SEQ_STALL_EN
    logic stall;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fft_seq_ctrl #(.R(5), .PIPE_LAT(3)) u_dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start),
`ifdef FFT_SEQ_STALL_EN
        .i_stall(stall),
`endif
        .o_busy(busy), .o_done(done), .o_rd_en(rd_en),
        .o_c(c), .o_b(b), .o_s(s),
        .o_wr_en(wr_en), .o_wr_c(wr_c), .o_wr_b(wr_b), .o_wr_s(wr_s)
    );

    fft_seq_ctrl #(.R(2), .PIPE_LAT(1)) u_r2 (
        .i_clk(clk), .i_rstn(rstn), .i_start(st2),
`ifdef FFT_SEQ_STALL_EN
        .i_stall(1'b0),
`endif
        .o_busy(busy2), .o_done(done2), .o_rd_en(rd2),
        .o_c(c2), .o_b(b2), .o_s(s2),
        .o_wr_en(wr2), .o_wr_c(wc2), .o_wr_b(wb2), .o_wr_s(ws2)
    );

    fft_seq_ctrl #(.R(4), .PIPE_LAT(5)) u_r4 (
        .i_clk(clk), .i_rstn(rstn), .i_start(st4),
`ifdef FFT_SEQ_STALL_EN
        .i_stall(1'b0),
`endif
        .o_busy(busy4), .o_done(done4), .o_rd_en(rd4),
        .o_c(c4), .o_b(b4), .o_s(s4),
        .o_wr_en(wr4), .o_wr_c(wc4), .o_wr_b(wb4), .o_wr_s(ws4)
    );

    function automatic logic par(logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return logic'(n % 2);
    endfunction

    // Cycle p after the start edge: stage = (p-1)/period, offset picks read or drain.
    function automatic exp_t model(int r, int l, int p);
        exp_t e;
        int h, per, tot, q;
        e   = '0;
        h   = 1 << (r - 1);
        per = h + l;
        tot = r * per;
        if (p >= 1 && p <= tot) begin
            e.busy = 1'b1;
            if ((p - 1) % per < h) begin
                e.rd = 1'b1;
                e.c  = 4'((p - 1) / per);
                e.b  = 16'((p - 1) % per);
                e.s  = par(e.b);
            end
        end else if (p == tot + 1) begin
            e.done = 1'b1;
        end
        q = p - l;
        if (q >= 1 && q <= tot && (q - 1) % per < h) begin
            e.wr = 1'b1;
            e.wc = 4'((q - 1) / per);
            e.wb = 16'((q - 1) % per);
            e.ws = par(e.wb);
        end
        return e;
    endfunction

    function automatic exp_t obs0();
        exp_t o;
        o = '{busy, done, rd_en, c, 16'(b), s, wr_en, wr_c, 16'(wr_b), wr_s};
        return o;
    endfunction

    function automatic exp_t obs2();
        exp_t o;
        o = '{busy2, done2, rd2, c2, 16'(b2), s2, wr2, wc2, 16'(wb2), ws2};
        return o;
    endfunction

    function automatic exp_t obs4();
        exp_t o;
        o = '{busy4, done4, rd4, c4, 16'(b4), s4, wr4, wc4, 16'(wb4), ws4};
        return o;
    endfunction

    task automatic test_reset();
        exp_t o;
        rstn  = 1'b0;
        start = 1'b0;
        st2   = 1'b0;
        st4   = 1'b0;
`ifdef FFT_SEQ_STALL_EN
        stall = 1'b0;
`endif
        #2;
        o = obs0();
        checks++;
        if (o !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%h want=0", o);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        o = obs0();
        checks++;
        if (o !== '0) begin
            fails++;
            $display("FAIL idle_after_reset got=%h want=0", o);
        end
    endtask

    // One full transform; optional random i_start noise while busy.
    task automatic test_transform(input bit noise);
        exp_t o, e;
        int nrd = 0, nwr = 0, nbusy = 0, ndone = 0;
        @(negedge clk);
        start = 1'b1;
        for (int t = 1; t <= 97; t++) begin
            @(negedge clk);
            o = obs0();
            e = model(5, 3, t);
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL xform_t%0d got=%h want=%h", t, o, e);
            end
            if (rd_en && wr_en) begin
                checks++;
                if (wr_c !== c) begin
                    fails++;
                    $display("FAIL overlap_t%0d wr_c=%0d c=%0d", t, wr_c, c);
                end
            end
            nrd   += int'(rd_en);
            nwr   += int'(wr_en);
            nbusy += int'(busy);
            ndone += int'(done);
            if (noise && t <= 95)
                start = (t == 10 || t == 50 || $urandom_range(0, 3) == 0);
            else
                start = 1'b0;
        end
        checks++;
        if (nrd != 80 || nwr != 80 || nbusy != 95 || ndone != 1) begin
            fails++;
            $display("FAIL xform_counts rd=%0d wr=%0d busy=%0d done=%0d want 80 80 95 1",
                     nrd, nwr, nbusy, ndone);
        end
    endtask

    task automatic test_back_to_back();
        exp_t o, e;
        int ndone = 0;
        @(negedge clk);
        start = 1'b1;
        for (int t = 1; t <= 194; t++) begin
            @(negedge clk);
            o = obs0();
            e = model(5, 3, ((t - 1) % 97) + 1);
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL b2b_t%0d got=%h want=%h", t, o, e);
            end
            if (done) begin
                ndone++;
                checks++;
                if (t != 96 && t != 193) begin
                    fails++;
                    $display("FAIL b2b_done_cycle got=%0d want=96/193", t);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 2) begin
            fails++;
            $display("FAIL b2b_done_count got=%0d want=2", ndone);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        exp_t o, e;
        int k;
        k = $urandom_range(20, 90);
        @(negedge clk);
        start = 1'b1;
        for (int t = 1; t <= k; t++) begin
            @(negedge clk);
            o = obs0();
            e = model(5, 3, t);
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL abort_pre_t%0d got=%h want=%h", t, o, e);
            end
            start = 1'b0;
        end
        rstn = 1'b0;
        #1;
        o = obs0();
        checks++;
        if (o !== '0) begin
            fails++;
            $display("FAIL abort_immediate k=%0d got=%h want=0", k, o);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            o = obs0();
            checks++;
            if (o !== '0) begin
                fails++;
                $display("FAIL abort_after_t%0d got=%h want=0", t, o);
            end
        end
        test_transform(1'b0);
    endtask

    task automatic test_param_sweep();
        exp_t o, e;
        int n2 = 0, n4 = 0;
        @(negedge clk);
        st2 = 1'b1;
        st4 = 1'b1;
        for (int t = 1; t <= 56; t++) begin
            @(negedge clk);
            st2 = 1'b0;
            st4 = 1'b0;
            o = obs2();
            e = model(2, 1, t);
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL sweep_r2_t%0d got=%h want=%h", t, o, e);
            end
            o = obs4();
            e = model(4, 5, t);
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL sweep_r4_t%0d got=%h want=%h", t, o, e);
            end
            n2 += int'(busy2);
            n4 += int'(busy4);
        end
        checks++;
        if (n2 != 6 || n4 != 52) begin
            fails++;
            $display("FAIL sweep_busy r2=%0d r4=%0d want 6 52", n2, n4);
        end
    endtask

`ifdef FFT_SEQ_STALL_EN
    // Schedule rebuilt by walking butterflies and skipping stalled cycles.
    task automatic test_stall();
        exp_t o, e;
        bit   stl [128];
        exp_t ex  [128];
        int   t, nbusy;
        for (int i = 0; i < 128; i++) begin
            stl[i] = (i >= 5 && i <= 7) || (i >= 30 && $urandom_range(0, 7) == 0);
            ex[i]  = '0;
        end
        t = 1;
        for (int cc = 0; cc < 5; cc++) begin
            for (int bb = 0; bb < 16; bb++) begin
                while (stl[t]) begin
                    ex[t].busy = 1'b1;
                    t++;
                end
                ex[t].busy = 1'b1;
                ex[t].rd   = 1'b1;
                ex[t].c    = 4'(cc);
                ex[t].b    = 16'(bb);
                ex[t].s    = par(16'(bb));
                t++;
            end
            for (int d = 0; d < 3; d++) begin
                ex[t].busy = 1'b1;
                t++;
            end
        end
        ex[t].done = 1'b1;
        for (int i = 4; i < 128; i++) begin
            ex[i].wr = ex[i-3].rd;
            ex[i].wc = ex[i-3].c;
            ex[i].wb = ex[i-3].b;
            ex[i].ws = ex[i-3].s;
        end
        nbusy = 0;
        @(posedge clk);
        #1 start = 1'b1;
        for (int i = 1; i <= t + 1; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            stall = stl[i];
            @(negedge clk);
            o = obs0();
            e = ex[i];
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL stall_t%0d got=%h want=%h", i, o, e);
            end
            nbusy += int'(busy);
        end
        stall = 1'b0;
        checks++;
        if (nbusy != t - 1) begin
            fails++;
            $display("FAIL stall_busy got=%0d want=%0d", nbusy, t - 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_transform(1'b0);
        test_transform(1'b1);
        test_back_to_back();
        test_abort();
        test_param_sweep();
`ifdef FFT_SEQ_STALL_EN
        test_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Sequencer for the in-place radix-2 FFT engine.
- Steps the stage counter c and the butterfly counter b across all R stages, and derives the bank-select/barrel-shift bit s.
- Issues read strobes to the address generator and memory banks, and produces matching write-back strobes delayed by the butterfly pipeline latency.
- Inserts drain cycles between stages so the in-place read-after-write ordering is preserved.

Parameters:
- R, 5, log2 of FFT size (N = 2^R); legal range 2..16.
- PIPE_LAT, 3, cycles from butterfly operand read to result write-back; legal range 1..15.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_start  input  1  start request; sampled only in IDLE.
- o_busy  output  1  high in RUN and DRAIN.
- o_done  output  1  single-cycle pulse when the transform completes.
- o_rd_en  output  1  read/issue strobe for the current butterfly.
- o_c  output  4  current stage index, 0..R-1, to the address-generator elements.
- o_b  output  R-1  current butterfly index, 0..2^(R-1)-1.
- o_s  output  1  bank-select/barrel-shift bit = XOR-reduce of o_b.
- o_wr_en  output  1  write-back strobe.
- o_wr_c  output  4  stage index of the butterfly being written.
- o_wr_b  output  R-1  butterfly index of the butterfly being written.
- o_wr_s  output  1  s value of the butterfly being written.

Behaviour:
- Reset (async, i_rstn=0): FSM=IDLE; all outputs 0; all counters 0; write pipeline valid bits cleared. Reset mid-transform aborts the transform with no o_done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - i_start=1 at a clock edge -> RUN with c=0, b=0.
  - Otherwise stay in IDLE.
- RUN:
  - o_rd_en=1; o_c=c; o_b=b; o_s=^b.
  - Each cycle b increments.
  - When b=2^(R-1)-1: b wraps to 0 and FSM -> DRAIN.
- DRAIN:
  - o_rd_en=0; a drain counter runs for exactly PIPE_LAT cycles.
  - Drain end with c<R-1: c increments, FSM -> RUN.
  - Drain end with c=R-1: c clears, FSM -> DONE.
- DONE: o_done=1 and o_busy=0 for one cycle; FSM -> IDLE.
- Outputs o_c, o_b and o_s are registered and are 0 whenever o_rd_en=0.
- Write pipeline:
  - Shift register of depth PIPE_LAT carrying {rd_en, c, b, s}.
  - o_wr_* is taken from the last stage, so o_wr_en rises exactly PIPE_LAT cycles after the corresponding o_rd_en.
  - o_wr_c, o_wr_b and o_wr_s are 0 when o_wr_en=0.
- Ordering guarantee: the last write of stage k occurs on the final DRAIN cycle of stage k; the first read of stage k+1 occurs on the next cycle. Read and write never overlap across a stage boundary.
- Timing: o_busy is high for exactly R*(2^(R-1)+PIPE_LAT) cycles; o_done follows on the next cycle.
- i_start is ignored in RUN, DRAIN and DONE. It is not queued.
- i_start held high continuously: a new transform starts on the first IDLE edge, one cycle after the o_done pulse.
- Counter widths are exact; no arithmetic overflow beyond the defined wrap.

Optional Feature:
- Macro: FFT_SEQ_STALL_EN.
- Defined:
  - Adds input port i_stall (1 bit), placed after i_start.
  - i_stall=1 in RUN: c and b hold, o_rd_en=0, and a bubble (valid=0) enters the write pipeline.
  - The write pipeline always advances, even during a stall.
  - i_stall has no effect in IDLE, DRAIN or DONE. DRAIN length is unchanged.
  - o_busy cycle count grows by the number of stalled RUN cycles.
- Undefined: no i_stall port; behaviour is identical to i_stall tied 0.

Test Plan:
- Reset then start (R=5, PIPE_LAT=3); pulse i_start at cycle 0 -> RUN with o_c=0, o_b=0 at cycle 1; o_busy high for exactly 95 cycles; o_done pulses once at cycle 96; exactly 80 o_rd_en and 80 o_wr_en pulses.
- Stage 0 -> 1 boundary -> o_rd_en high cycles 1..16 with o_b=0..15 and o_s=parity(o_b); o_wr_en high cycles 4..19 with o_wr_c=0 and o_wr_b=0..15; first o_c=1 read at cycle 20; no cycle has o_rd_en and o_wr_en for different stages both high.
- i_start pulsed at cycles 10 and 50 during a transform -> ignored; exactly one o_done in 96 cycles. i_start held high -> back-to-back transforms, o_done every 97 cycles.
- i_rstn low at cycle 40 (mid stage 2) -> all outputs 0 immediately; no o_done; no o_wr_en after release. Next i_start runs a full clean 95-cycle transform.
- Parameter sweep R=2/PIPE_LAT=1 and R=4/PIPE_LAT=5 -> o_busy length 2*(2+1)=6 and 4*(8+5)=52 cycles; o_c stays within 0..R-1.
- With FFT_SEQ_STALL_EN: i_stall high cycles 5..7 in stage 0 -> o_b holds at 4 with o_rd_en=0 for those cycles; o_wr_en shows a 3-cycle gap at cycles 8..10; total o_busy=98.
